mips_sequencer: RTL and testbench

MIPS_SEQUENCER -- requirements
Module: mips_sequencer

---
 rtl/mips_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_mips_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_sequencer.sv
// Multi-cycle MIPS control sequencer: IDLE -> DECODE -> EXEC -> (MEM) -> WB, with a bounded memory wait.
// Latency: R-type 4 edges accept-to-DONE; LW 5 + ack-wait; SW 4 + ack-wait; unknown opcode 2 edges to ILLEGAL.
// Backpressure: INSTR_READY is high only in IDLE outside reset; MEM stalls on MEM_ACK until TIMEOUT cycles pass.
//
// Ports:
//   CLK, RST (sync, active-high)           clock and reset
//   INSTR, INSTR_VALID / INSTR_READY       instruction handshake; fields Op[31:26] WA[14:10] RA1[9:5] RA2[4:0]
//   MEM_ACK                                data memory finished the current access
//   ALU_op, RA1_O, RA2_O, WA_O             decoded controls from the latched instruction
//   BRWe, WeMD, ReMD, Demuxo               register-file / data-memory enables and writeback select
//   BUSY, DONE, ILLEGAL, TIMEOUT_ERR       status level and one-cycle pulses
//   RETIRED                                16-bit wrapping retired-instruction count
module mips_sequencer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] INSTR,
   input  logic        INSTR_VALID,
   output logic        INSTR_READY,
   input  logic        MEM_ACK,
   output logic [3:0]  ALU_op,
   output logic [4:0]  RA1_O,
   output logic [4:0]  RA2_O,
   output logic [4:0]  WA_O,
   output logic        BRWe,
   output logic        WeMD,
   output logic        ReMD,
   output logic        Demuxo,
   output logic        BUSY,
   output logic        DONE,
   output logic        ILLEGAL,
   output logic        TIMEOUT_ERR,
   output logic [15:0] RETIRED
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_SLT = 6'b101010;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;

   // The counter holds the number of earlier ack-less MEM cycles, so the
   // current ack-less cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [5:0]  op_q, op_d;
   logic [4:0]  wa_q, wa_d;
   logic [4:0]  ra1_q, ra1_d;
   logic [4:0]  ra2_q, ra2_d;
   logic [7:0]  wait_q, wait_d;
   logic [15:0] retired_q, retired_d;
   logic        done_q, done_d;
   logic        illegal_q, illegal_d;
   logic        tmo_q, tmo_d;

   logic        known, is_lw, is_sw;
   logic [3:0]  alu;
   logic        brwe, wemd, remd, demux;
   logic        accept;
   logic        instr_unused;

   // Immediate/function bits are not used by this sequencer.
   assign instr_unused = ^INSTR[25:15];

   // Opcode decode of the latched instruction; unknown opcodes present ALU_op 0000.
   always_comb begin
      known = 1'b1;
      is_lw = 1'b0;
      is_sw = 1'b0;
      alu   = 4'b0000;
      case (op_q)
         OP_ADD: alu = 4'b0010;
         OP_SUB: alu = 4'b0110;
         OP_AND: alu = 4'b0000;
         OP_OR:  alu = 4'b0001;
         OP_SLT: alu = 4'b0111;
         OP_LW:  begin alu = 4'b0010; is_lw = 1'b1; end
         OP_SW:  begin alu = 4'b0010; is_sw = 1'b1; end
         default: known = 1'b0;
      endcase
   end

   assign accept = INSTR_VALID && INSTR_READY;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      wa_d      = wa_q;
      ra1_d     = ra1_q;
      ra2_d     = ra2_q;
      wait_d    = wait_q;
      retired_d = retired_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      tmo_d     = 1'b0;
      brwe      = 1'b0;
      wemd      = 1'b0;
      remd      = 1'b0;
      demux     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = INSTR[31:26];
               wa_d    = INSTR[14:10];
               ra1_d   = INSTR[9:5];
               ra2_d   = INSTR[4:0];
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (known) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_IDLE;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            wait_d  = 8'd0;
            state_d = (is_lw || is_sw) ? S_MEM : S_WB;
         end
         S_MEM: begin
            remd = is_lw;
            wemd = is_sw;
            // An ack in the final allowed cycle still completes normally.
            if (MEM_ACK) begin
               if (is_lw) begin
                  state_d = S_WB;
               end else begin
                  state_d   = S_IDLE;
                  done_d    = 1'b1;
                  retired_d = retired_q + 16'd1;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_IDLE;
               tmo_d   = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB: begin
            brwe      = 1'b1;
            demux     = !is_lw;
            remd      = is_lw;
            state_d   = S_IDLE;
            done_d    = 1'b1;
            retired_d = retired_q + 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         op_q      <= 6'd0;
         wa_q      <= 5'd0;
         ra1_q     <= 5'd0;
         ra2_q     <= 5'd0;
         wait_q    <= 8'd0;
         retired_q <= 16'd0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         wa_q      <= wa_d;
         ra1_q     <= ra1_d;
         ra2_q     <= ra2_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         tmo_q     <= tmo_d;
      end
   end

   assign INSTR_READY = (state_q == S_IDLE) && !RST;
   assign BUSY        = (state_q != S_IDLE) && !RST;
   assign ALU_op      = alu;
   assign RA1_O       = ra1_q;
   assign RA2_O       = ra2_q;
   assign WA_O        = wa_q;
   assign BRWe        = brwe;
   assign WeMD        = wemd;
   assign ReMD        = remd;
   assign Demuxo      = demux;
   assign DONE        = done_q;
   assign ILLEGAL     = illegal_q;
   assign TIMEOUT_ERR = tmo_q;
   assign RETIRED     = retired_q;

endmodule

// File: tb/tb_mips_sequencer.sv
module tb_mips_sequencer;

   localparam int TO = 15;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] INSTR = 32'd0;
   logic        INSTR_VALID = 1'b0;
   logic        MEM_ACK = 1'b0;
   logic        INSTR_READY;
   logic [3:0]  ALU_op;
   logic [4:0]  RA1_O, RA2_O, WA_O;
   logic        BRWe, WeMD, ReMD, Demuxo, BUSY, DONE, ILLEGAL, TIMEOUT_ERR;
   logic [15:0] RETIRED;

   mips_sequencer #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
      .INSTR_READY(INSTR_READY), .MEM_ACK(MEM_ACK), .ALU_op(ALU_op),
      .RA1_O(RA1_O), .RA2_O(RA2_O), .WA_O(WA_O), .BRWe(BRWe), .WeMD(WeMD),
      .ReMD(ReMD), .Demuxo(Demuxo), .BUSY(BUSY), .DONE(DONE), .ILLEGAL(ILLEGAL),
      .TIMEOUT_ERR(TIMEOUT_ERR), .RETIRED(RETIRED)
   );

   always #5 CLK = ~CLK;

   // One observation of every output in a cycle.
   typedef struct packed {
      logic        rdy, busy, done, ill, tmo, brwe, wemd, remd, dmx;
      logic [3:0]  alu;
      logic [4:0]  ra1, ra2, wa;
      logic [15:0] ret;
   } obs_t;

   typedef struct {
      int   cyc;
      obs_t o;
   } rec_t;

   rec_t        expq[$];
   obs_t        idle_o = '0;
   int          cyc = 0;
   int          ack_cyc = -1;
   logic        rst_q = 1'b0;
   logic [15:0] m_ret = 16'd0;
   int          n_vec = 0;
   int          n_err = 0;

   int          brwe_cnt, remd_cnt, wemd_cnt, done_cnt;
   logic [3:0]  wb_alu;
   logic [4:0]  wb_ra1, wb_ra2, wb_wa;
   logic        wb_dmx;

   // Cycle counter, reset sampling, and the memory acknowledge for the scheduled cycle.
   always @(posedge CLK) begin
      rst_q = RST;
      cyc++;
      #1;
      MEM_ACK = (cyc == ack_cyc);
   end

   // Opcode table: kind 0 unknown, 1 R-type, 2 LW, 3 SW.
   function automatic void model_op(input logic [5:0] op, output int kind, output logic [3:0] alu);
      kind = 1;
      alu  = 4'b0000;
      case (op)
         6'b100000: alu = 4'b0010;
         6'b100010: alu = 4'b0110;
         6'b100100: alu = 4'b0000;
         6'b100101: alu = 4'b0001;
         6'b101010: alu = 4'b0111;
         6'b100011: begin kind = 2; alu = 4'b0010; end
         6'b101011: begin kind = 3; alu = 4'b0010; end
         default:   kind = 0;
      endcase
   endfunction

   function automatic void push(input int c, input obs_t o);
      rec_t r;
      r.cyc = c;
      r.o   = o;
      expq.push_back(r);
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr_stats();
      brwe_cnt = 0; remd_cnt = 0; wemd_cnt = 0; done_cnt = 0;
      wb_alu = 'x; wb_ra1 = 'x; wb_ra2 = 'x; wb_wa = 'x; wb_dmx = 1'bx;
   endtask

   // Present one instruction in the current (idle) cycle and predict the whole
   // cycle-by-cycle trace.  k = MEM cycle carrying the ack (1-based), 0 = never.
   // len = number of cycles from accept to the pulse cycle.
   task automatic issue(input logic [31:0] ins, input int k, output int len);
      int         start, kind, nmem;
      logic [3:0] alu;
      obs_t       b, o;
      bit         acked;
      start = cyc;
      model_op(ins[31:26], kind, alu);
      b = '0;
      b.busy = 1'b1; b.alu = alu; b.ret = m_ret;
      b.ra1 = ins[9:5]; b.ra2 = ins[4:0]; b.wa = ins[14:10];
      push(start + 1, b);
      if (kind == 0) begin
         b.busy = 1'b0; b.rdy = 1'b1; b.ill = 1'b1;
         len = 2;
         push(start + len, b);
      end else begin
         push(start + 2, b);
         len = 2;
         acked = 1'b1;
         if (kind == 1) begin
            o = b; o.brwe = 1'b1; o.dmx = 1'b1;
            len++; push(start + len, o);
         end else begin
            acked = (k >= 1 && k <= TO);
            nmem  = acked ? k : TO;
            for (int j = 0; j < nmem; j++) begin
               o = b; o.remd = (kind == 2); o.wemd = (kind == 3);
               len++; push(start + len, o);
            end
            if (acked && kind == 2) begin
               o = b; o.brwe = 1'b1; o.remd = 1'b1;
               len++; push(start + len, o);
            end
         end
         b.busy = 1'b0; b.rdy = 1'b1;
         if (acked) begin
            m_ret  = m_ret + 16'd1;
            b.ret  = m_ret;
            b.done = 1'b1;
         end else begin
            b.tmo = 1'b1;
         end
         len++; push(start + len, b);
      end
      ack_cyc     = (kind >= 2 && k >= 1) ? start + 2 + k : -1;
      INSTR       = ins;
      INSTR_VALID = 1'b1;
      tick(1);
      INSTR_VALID = 1'b0;
      INSTR       = 32'hDEAD_BEEF;
   endtask

   // Single compare process: every cycle against the predicted trace.
   always @(negedge CLK) begin : compare
      obs_t e, a;
      rec_t r;
      a = {INSTR_READY, BUSY, DONE, ILLEGAL, TIMEOUT_ERR, BRWe, WeMD, ReMD, Demuxo,
           ALU_op, RA1_O, RA2_O, WA_O, RETIRED};
      if (RST && !rst_q) begin
         // Reset requested but not yet sampled: only the handshake levels are defined.
         n_vec++;
         if (a.rdy !== 1'b0 || a.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_levels cyc%0d: got rdy=%b busy=%b expected 0 0", cyc, a.rdy, a.busy);
         end
      end else begin
         if (rst_q) begin
            expq.delete();
            idle_o = '0;
            idle_o.rdy = 1'b1;
         end
         while (expq.size() > 0 && expq[0].cyc < cyc) begin
            r = expq.pop_front();
            n_vec++; n_err++;
            $display("FAIL stale_record cyc%0d: record for cyc%0d never matched", cyc, r.cyc);
         end
         if (expq.size() > 0 && expq[0].cyc == cyc) begin
            r = expq.pop_front();
            e = r.o;
            idle_o = e;
            idle_o.rdy = 1'b1; idle_o.busy = 1'b0;
            idle_o.done = 1'b0; idle_o.ill = 1'b0; idle_o.tmo = 1'b0;
            idle_o.brwe = 1'b0; idle_o.wemd = 1'b0; idle_o.remd = 1'b0; idle_o.dmx = 1'b0;
         end else begin
            e = idle_o;
         end
         if (RST) e.rdy = 1'b0;
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL outputs cyc%0d: got %h expected %h", cyc, a, e);
         end
      end
      if (BRWe === 1'b1) begin
         brwe_cnt++;
         wb_alu = ALU_op; wb_ra1 = RA1_O; wb_ra2 = RA2_O; wb_wa = WA_O; wb_dmx = Demuxo;
      end
      if (ReMD === 1'b1) remd_cnt++;
      if (WeMD === 1'b1) wemd_cnt++;
      if (DONE === 1'b1) done_cnt++;
   end

   logic [31:0] t_ins [12] = '{32'h8800_7FFF, 32'h9000_0421, 32'h9400_28C6, 32'hA800_7C1F,
                               32'h8C00_0000, 32'hAC00_1234, 32'hAC00_4321, 32'h8C00_5555,
                               32'h8C00_2AAA, 32'hAC00_0F0F, 32'h0000_0000, 32'h8400_0000};
   int          t_k   [12] = '{0, 0, 0, 0, 1, 1, 15, 15, 0, 16, 0, 0};

   initial begin
      int len;
      clr_stats();
      tick(3);
      chk("reset_ready", INSTR_READY, 0);
      chk("reset_busy", BUSY, 0);
      chk("reset_retired", RETIRED, 0);
      RST = 1'b0;
      tick(1);
      chk("post_reset_ready", INSTR_READY, 1);

      // ADD r3 = r1 + r2
      clr_stats();
      issue(32'h8000_0C22, 0, len);
      tick(len - 1);
      chk("add_done_edge4", DONE, 1);
      chk("add_len", len, 4);
      chk("add_retired", RETIRED, 1);
      chk("add_wb_wa", wb_wa, 3);
      chk("add_wb_ra1", wb_ra1, 1);
      chk("add_wb_ra2", wb_ra2, 2);
      chk("add_wb_alu", wb_alu, 4'b0010);
      chk("add_wb_demux", wb_dmx, 1);

      // LW acked on the 3rd MEM cycle, issued in the ADD's DONE cycle;
      // a stray request while busy must be ignored.
      clr_stats();
      issue(32'h8C00_0C22, 3, len);
      INSTR = 32'h9400_7FFF; INSTR_VALID = 1'b1;
      tick(2);
      INSTR_VALID = 1'b0;
      tick(len - 3);
      chk("lw_done_edge7", DONE, 1);
      chk("lw_len", len, 7);
      chk("lw_remd_cycles", remd_cnt, 4);
      chk("lw_brwe_cycles", brwe_cnt, 1);
      chk("lw_wb_demux", wb_dmx, 0);
      chk("lw_retired", RETIRED, 2);

      // SW never acked: abort after TIMEOUT MEM cycles.
      clr_stats();
      issue(32'hAC00_0C22, 0, len);
      tick(len - 1);
      chk("sw_timeout_pulse", TIMEOUT_ERR, 1);
      chk("sw_wemd_cycles", wemd_cnt, 15);
      chk("sw_brwe_cycles", brwe_cnt, 0);
      chk("sw_retired", RETIRED, 2);

      // Illegal opcode, then ADD accepted in the ILLEGAL cycle.
      clr_stats();
      issue(32'hFC00_0000, 0, len);
      tick(len - 1);
      chk("ill_pulse", ILLEGAL, 1);
      chk("ill_ready", INSTR_READY, 1);
      chk("ill_enables", brwe_cnt + remd_cnt + wemd_cnt, 0);
      chk("ill_retired", RETIRED, 2);
      issue(32'h8000_0C22, 0, len);
      tick(len - 1);
      chk("b2b_add_retired", RETIRED, 3);

      // Assorted opcodes and ack timings, with and without idle gaps.
      for (int i = 0; i < 12; i++) begin
         issue(t_ins[i], t_k[i], len);
         tick(len - 1);
         tick(i % 3);
      end

      // Reset while an LW waits in MEM.
      clr_stats();
      issue(32'h8C00_0C22, 0, len);
      tick(3);
      chk("pre_rst_remd", ReMD, 1);
      RST = 1'b1;
      tick(1);
      RST = 1'b0;
      m_ret = 16'd0;
      ack_cyc = -1;
      tick(3);
      chk("rst_retired", RETIRED, 0);
      chk("rst_no_done", done_cnt, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_brwe", brwe_cnt, 0);

      // Counter wrap from 0xFFFF.
      dut.retired_q = 16'hFFFF;
      m_ret  = 16'hFFFF;
      idle_o.ret = 16'hFFFF;
      tick(1);
      issue(32'h8000_0C22, 0, len);
      tick(len - 1);
      chk("wrap_done", DONE, 1);
      chk("wrap_retired", RETIRED, 0);

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
